// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-side definitions.
// FSM encoding and default PC geometry.
package fetch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fru_state_e;

  localparam int SIZE_DEF        = 31;
  localparam int INSTR_BYTES_DEF = 4;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory request/response bus.
// The fetch unit is the master.
interface fetch_redirect_unit_if #(
  parameter int SIZE = 31
) ();

  logic          imem_req;
  logic [SIZE:0] imem_addr;
  logic          imem_ready;
  logic [SIZE:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch stage: owns PCF, talks to imem, fills IF/ID.
// Redirects flush IF/ID and discard in-flight fetches.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int            SIZE        = SIZE_DEF,
  parameter logic [SIZE:0] RESET_PC    = '0,
  parameter int            INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SIZE:0]         PCTick,
  input  logic                  clk1clear,
  input  logic                  StallF,
  input  logic                  StallD,
  fetch_redirect_unit_if.master imem,
  output logic [SIZE:0]         PCF,
  output logic [SIZE:0]         PCPlusF,
  output logic [SIZE:0]         InstrD,
  output logic [SIZE:0]         PCPlusFD,
  output logic                  ValidD
);

  localparam logic [SIZE:0] INC = (SIZE+1)'(INSTR_BYTES);

  fru_state_e    state_q, state_d;
  logic [SIZE:0] pcf_q, pcf_d;
  logic [SIZE:0] req_addr_q, req_addr_d;
  logic [SIZE:0] instr_q, instr_d;
  logic [SIZE:0] pcplus_q, pcplus_d;
  logic          valid_q, valid_d;
  logic [SIZE:0] hold_q, hold_d;
  logic          launch;
  logic [SIZE:0] launch_addr;
  logic [SIZE:0] nxt_addr;

  assign nxt_addr       = req_addr_q + INC;
  assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem.imem_addr = req_addr_q;
  assign PCF            = pcf_q;
  assign PCPlusF        = pcf_q + INC;
  assign InstrD         = instr_q;
  assign PCPlusFD       = pcplus_q;
  assign ValidD         = valid_q;

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    req_addr_d  = req_addr_q;
    instr_d     = instr_q;
    pcplus_d    = pcplus_q;
    valid_d     = valid_q;
    hold_d      = hold_q;
    launch      = 1'b0;
    launch_addr = pcf_q;
    unique case (state_q)
      S_IDLE: begin
        if (clk1clear) begin
          pcf_d   = PCTick;
          valid_d = 1'b0;
        end else begin
          if (!StallD) valid_d = 1'b0;
          launch = 1'b1;
        end
      end
      S_REQ: begin
        if (clk1clear) begin
          pcf_d   = PCTick;
          valid_d = 1'b0;
          if (imem.imem_ready) begin
            launch      = 1'b1;
            launch_addr = PCTick;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imem.imem_ready) begin
          pcf_d = nxt_addr;
          if (!StallD) begin
            instr_d     = imem.imem_rdata;
            pcplus_d    = nxt_addr;
            valid_d     = 1'b1;
            launch      = 1'b1;
            launch_addr = nxt_addr;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (!StallD) begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (clk1clear) begin
          pcf_d   = PCTick;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (!StallD) begin
          instr_d  = hold_q;
          pcplus_d = pcf_q;
          valid_d  = 1'b1;
          launch   = 1'b1;
        end
      end
      S_DRAIN: begin
        // Old request still owns the bus; its data is never used.
        valid_d = 1'b0;
        if (clk1clear) pcf_d = PCTick;
        if (imem.imem_ready) begin
          launch      = 1'b1;
          launch_addr = clk1clear ? PCTick : pcf_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      if (!StallF) begin
        req_addr_d = launch_addr;
        state_d    = S_REQ;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pcf_q      <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= '0;
      pcplus_q   <= '0;
      valid_q    <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pcplus_q   <= pcplus_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: transaction model plus
// directed redirect/stall/latency scenarios.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pctick;
  logic        clr;
  logic        stallf;
  logic        stalld;
  logic        rdy;
  logic [31:0] pcf, pcplusf, instrd, pcplusfd;
  logic        validd;

  int checks = 0;
  int errors = 0;

  fetch_redirect_unit_if #(.SIZE(31)) bus ();

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.imem_ready = rdy;
  assign bus.imem_rdata = instr_of(bus.imem_addr);

  fetch_redirect_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PCTick    (pctick),
    .clk1clear (clr),
    .StallF    (stallf),
    .StallD    (stalld),
    .imem      (bus.master),
    .PCF       (pcf),
    .PCPlusF   (pcplusf),
    .InstrD    (instrd),
    .PCPlusFD  (pcplusfd),
    .ValidD    (validd)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding fetch, an optional
  // parked instruction, and a flag marking the in-flight fetch stale.
  logic [31:0] m_pcf, m_addr, m_hold, m_instr, m_pplus;
  logic        m_busy, m_doomed, m_held, m_valid, m_go;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pcf = 0; m_addr = 0; m_hold = 0; m_instr = 0; m_pplus = 0;
        m_busy = 0; m_doomed = 0; m_held = 0; m_valid = 0;
      end else begin
        m_go = 0;
        if (m_busy) begin
          if (rdy) begin
            m_busy = 0;
            if (clr) begin
              m_pcf = pctick; m_valid = 0; m_go = 1;
            end else if (m_doomed) begin
              m_valid = 0; m_go = 1;
            end else if (!stalld) begin
              m_instr = instr_of(m_addr);
              m_pplus = m_addr + 4;
              m_pcf = m_addr + 4;
              m_valid = 1; m_go = 1;
            end else begin
              m_hold = instr_of(m_addr);
              m_pcf = m_addr + 4;
              m_held = 1;
            end
            m_doomed = 0;
          end else if (clr) begin
            m_pcf = pctick; m_doomed = 1; m_valid = 0;
          end else if (m_doomed || !stalld) begin
            m_valid = 0;
          end
        end else if (m_held) begin
          if (clr) begin
            m_held = 0; m_pcf = pctick; m_valid = 0;
          end else if (!stalld) begin
            m_held = 0; m_instr = m_hold; m_pplus = m_pcf;
            m_valid = 1; m_go = 1;
          end
        end else if (clr) begin
          m_pcf = pctick; m_valid = 0;
        end else begin
          if (!stalld) m_valid = 0;
          m_go = 1;
        end
        if (m_go && !stallf) begin
          m_busy = 1; m_addr = m_pcf;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("imem_req", 32'(bus.imem_req), 32'(m_busy));
      chk("imem_addr", bus.imem_addr, m_addr);
      chk("PCF", pcf, m_pcf);
      chk("PCPlusF", pcplusf, m_pcf + 4);
      chk("ValidD", 32'(validd), 32'(m_valid));
      if (m_valid) begin
        chk("InstrD", instrd, m_instr);
        chk("PCPlusFD", pcplusfd, m_pplus);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(logic [31:0] a);
    int k = 0;
    while (!(bus.imem_req === 1'b1 && bus.imem_addr === a) && k < 50) begin
      step();
      k++;
    end
    chk("wait_addr", bus.imem_addr, a);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_req"}, 32'(bus.imem_req), 0);
    chk({nm, "_addr"}, bus.imem_addr, 0);
    chk({nm, "_PCF"}, pcf, 0);
    chk({nm, "_ValidD"}, 32'(validd), 0);
    chk({nm, "_InstrD"}, instrd, 0);
    chk({nm, "_PCPlusFD"}, pcplusfd, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; pctick = 0; clr = 0;
    stallf = 0; stalld = 0; rdy = 0;
    step();
    chk_reset("rst");
    step();
    rst_n = 1;
    rdy = 1;
    step();
    chk("first_req", 32'(bus.imem_req), 1);
    chk("first_addr", bus.imem_addr, 0);
    chk("first_valid", 32'(validd), 0);
    step();
    chk("cap0_valid", 32'(validd), 1);
    chk("cap0_instr", instrd, instr_of(0));
    chk("cap0_pplus", pcplusfd, 32'h4);
    chk("cap0_addr", bus.imem_addr, 32'h4);

    wait_addr(32'h10);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", 32'(bus.imem_req), 1);
      chk("wait_addr10", bus.imem_addr, 32'h10);
      chk("wait_bubble", 32'(validd), 0);
    end
    rdy = 1;
    step();
    chk("late_instr", instrd, instr_of(32'h10));
    chk("late_pplus", pcplusfd, 32'h14);
    chk("late_valid", 32'(validd), 1);

    wait_addr(32'h20);
    rdy = 0; clr = 1; pctick = 32'h100;
    step();
    clr = 0;
    chk("drain_addr", bus.imem_addr, 32'h20);
    chk("drain_req", 32'(bus.imem_req), 1);
    chk("drain_pcf", pcf, 32'h100);
    chk("drain_valid", 32'(validd), 0);
    step();
    rdy = 1;
    step();
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_valid", 32'(validd), 0);
    step();
    chk("redir_instr", instrd, instr_of(32'h100));
    chk("redir_vld1", 32'(validd), 1);

    clr = 1; pctick = 32'h40;
    step();
    clr = 0;
    chk("rr_addr", bus.imem_addr, 32'h40);
    chk("rr_valid", 32'(validd), 0);
    stalld = 1;
    step();
    chk("hold_req", 32'(bus.imem_req), 0);
    chk("hold_pcf", pcf, 32'h44);
    chk("hold_instr", instrd, instr_of(32'h100));
    step();
    stalld = 0;
    step();
    chk("unhold_instr", instrd, instr_of(32'h40));
    chk("unhold_pplus", pcplusfd, 32'h44);
    chk("unhold_addr", bus.imem_addr, 32'h44);

    stalld = 1;
    step();
    clr = 1; pctick = 32'h200;
    step();
    clr = 0; stalld = 0;
    chk("hflush_valid", 32'(validd), 0);
    chk("hflush_pcf", pcf, 32'h200);
    step();
    chk("hflush_addr", bus.imem_addr, 32'h200);
    step();
    chk("hflush_instr", instrd, instr_of(32'h200));

    stallf = 1;
    step();
    chk("stallf_req", 32'(bus.imem_req), 0);
    chk("stallf_pcf", pcf, 32'h208);
    stallf = 0;
    step();
    chk("stallf_addr", bus.imem_addr, 32'h208);

    clr = 1; pctick = 32'hFFFF_FFFC;
    step();
    clr = 0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pplus", pcplusfd, 32'h0);
    chk("wrap_next", bus.imem_addr, 32'h0);

    step();
    rdy = 0; clr = 1; pctick = 32'h300;
    step();
    clr = 0;
    chk("pre_rst_addr", bus.imem_addr, 32'h4);
    #2;
    rst_n = 0;
    #1;
    chk_reset("midrst");
    step();
    rst_n = 1;
    rdy = 1;
    step();
    chk("restart_addr", bus.imem_addr, 32'h0);
    chk("restart_req", 32'(bus.imem_req), 1);
    step();
    chk("restart_instr", instrd, instr_of(0));
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
